// File: rtl/punc_mem_arbiter.sv
// punc_mem_arbiter
// ----------------
// Shares the single PUnC memory port between the processor (CPU) and the
// debug/loader port (DBG). Memory is asynchronous-read, synchronous-write,
// so the granted requester drives the memory directly in its grant cycle and
// the read data is captured into that requester's rdata register at the
// closing clock edge.
//
// Ties are broken round-robin using the identity of the last granted
// requester. DBG may lock the port after one of its grants. The lock is
// released when DBG drops dbg_lock, or forcibly after LOCK_MAX locked cycles.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   cpu_req/we/addr/wdata   CPU request (held until cpu_gnt)
//   cpu_gnt          CPU access performed this cycle
//   cpu_rvalid/rdata CPU read return (rvalid one cycle after a read grant)
//   dbg_req/we/lock/addr/wdata  DBG request, lock asks for exclusive ownership
//   dbg_gnt          DBG access performed this cycle
//   dbg_rvalid/rdata DBG read return
//   mem_addr/we/wdata  memory request, driven by the granted requester
//   mem_rdata        memory asynchronous read data
//   locked           arbiter is in the LOCK state
module punc_mem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              locked
);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_LOCK   = 1'b1
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  localparam logic [7:0] LockMax = 8'(LOCK_MAX);

  state_e            state_q, state_d;
  owner_e            last_q, last_d;
  logic [7:0]        lock_cnt_q, lock_cnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              cpu_gnt_w, dbg_gnt_w;

  // State register. Reset leaves last=DBG so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_NORMAL;
      last_q       <= OWN_DBG;
      lock_cnt_q   <= 8'd0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      lock_cnt_q   <= lock_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Grant decision. Reset masks both grants so nothing commits to memory
  // in a reset cycle; while locked only DBG can be served.
  always_comb begin
    cpu_gnt_w = 1'b0;
    dbg_gnt_w = 1'b0;
    if (!rst) begin
      if (state_q == ST_LOCK) begin
        dbg_gnt_w = dbg_req;
      end else if (cpu_req && dbg_req) begin
        if (last_q == OWN_DBG) begin
          cpu_gnt_w = 1'b1;
        end else begin
          dbg_gnt_w = 1'b1;
        end
      end else begin
        cpu_gnt_w = cpu_req;
        dbg_gnt_w = dbg_req;
      end
    end
  end

  // Memory port mux: the idle port is driven to all zeros.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (cpu_gnt_w) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt_w) begin
      mem_addr  = dbg_addr;
      mem_we    = dbg_we;
      mem_wdata = dbg_wdata;
    end
  end

  // Next-state logic: round-robin history, read capture and lock FSM.
  // Leaving LOCK always records DBG as last so the CPU wins the next tie,
  // which bounds CPU starvation to LOCK_MAX+1 cycles.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    lock_cnt_d   = lock_cnt_q;
    cpu_rvalid_d = cpu_gnt_w && !cpu_we;
    dbg_rvalid_d = dbg_gnt_w && !dbg_we;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;

    if (cpu_gnt_w) begin
      last_d = OWN_CPU;
    end
    if (dbg_gnt_w) begin
      last_d = OWN_DBG;
    end
    if (cpu_rvalid_d) begin
      cpu_rdata_d = mem_rdata;
    end
    if (dbg_rvalid_d) begin
      dbg_rdata_d = mem_rdata;
    end

    if (state_q == ST_NORMAL) begin
      if (dbg_gnt_w && dbg_lock) begin
        state_d    = ST_LOCK;
        lock_cnt_d = 8'd1;
      end
    end else begin
      if (!dbg_lock || (lock_cnt_q == LockMax)) begin
        state_d    = ST_NORMAL;
        last_d     = OWN_DBG;
        lock_cnt_d = 8'd0;
      end else begin
        lock_cnt_d = lock_cnt_q + 8'd1;
      end
    end
  end

  // Registered outputs and FSM status.
  always_comb begin
    cpu_gnt    = cpu_gnt_w;
    dbg_gnt    = dbg_gnt_w;
    cpu_rvalid = cpu_rvalid_q;
    dbg_rvalid = dbg_rvalid_q;
    cpu_rdata  = cpu_rdata_q;
    dbg_rdata  = dbg_rdata_q;
    locked     = (state_q == ST_LOCK);
  end

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Testbench for punc_mem_arbiter: a 64K-word memory environment, a
// behavioural arbiter model, a table of directed vectors, hand-written
// corner-case sequences and a randomized phase.
module tb_punc_mem_arbiter;

  localparam int LOCK_MAX = 8;

  logic        clk;
  logic        rst;
  logic        cpuReq, cpuWe, cpuGnt, cpuRvalid;
  logic [15:0] cpuAddr, cpuWdata, cpuRdata;
  logic        dbgReq, dbgWe, dbgLock, dbgGnt, dbgRvalid;
  logic [15:0] dbgAddr, dbgWdata, dbgRdata;
  logic [15:0] memAddr, memWdata, memRdata;
  logic        memWe, locked;

  int checkCount;
  int errorCount;

  // Memory seen by the DUT, and the independent copy kept by the model.
  logic [15:0] memArray [0:65535];
  logic [15:0] refMem   [0:65535];

  // Model state: ownership history, lock status and read-return registers.
  bit          refLocked;
  bit          refLastDbg;
  int          refHeld;
  bit          refCpuRvalid, refDbgRvalid;
  logic [15:0] refCpuRdata, refDbgRdata;
  bit          expC, expD;

  typedef struct {
    logic        cReq;
    logic        cWe;
    logic [15:0] cAddr;
    logic [15:0] cWdata;
    logic        dReq;
    logic        dWe;
    logic        dLock;
    logic [15:0] dAddr;
    logic [15:0] dWdata;
    logic        eCpuGnt;
    logic        eDbgGnt;
    logic        eMemWe;
    logic        eLocked;
    logic        chkRd;
    logic [15:0] eRd;
  } vec_t;

  vec_t vecs[$];

  punc_mem_arbiter #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpuReq),
    .cpu_we    (cpuWe),
    .cpu_addr  (cpuAddr),
    .cpu_wdata (cpuWdata),
    .cpu_gnt   (cpuGnt),
    .cpu_rvalid(cpuRvalid),
    .cpu_rdata (cpuRdata),
    .dbg_req   (dbgReq),
    .dbg_we    (dbgWe),
    .dbg_lock  (dbgLock),
    .dbg_addr  (dbgAddr),
    .dbg_wdata (dbgWdata),
    .dbg_gnt   (dbgGnt),
    .dbg_rvalid(dbgRvalid),
    .dbg_rdata (dbgRdata),
    .mem_addr  (memAddr),
    .mem_we    (memWe),
    .mem_wdata (memWdata),
    .mem_rdata (memRdata),
    .locked    (locked)
  );

  // Free-running clock, first rising edge at 5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Asynchronous-read memory environment.
  assign memRdata = memArray[memAddr];

  // Synchronous write port of the memory environment.
  always @(posedge clk) begin
    if (memWe) memArray[memAddr] <= memWdata;
  end

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkWord(input string name, input logic [15:0] act, input logic [15:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %04h expected %04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic cReq, input logic cWe,
                               input logic [15:0] cAddr, input logic [15:0] cWdata,
                               input logic dReq, input logic dWe, input logic dLock,
                               input logic [15:0] dAddr, input logic [15:0] dWdata);
    rst      = r;
    cpuReq   = cReq;
    cpuWe    = cWe;
    cpuAddr  = cAddr;
    cpuWdata = cWdata;
    dbgReq   = dReq;
    dbgWe    = dWe;
    dbgLock  = dLock;
    dbgAddr  = dAddr;
    dbgWdata = dWdata;
  endtask

  // Who should own the port this cycle, from the arbitration rules.
  task automatic predictGrants();
    expC = 1'b0;
    expD = 1'b0;
    if (!rst) begin
      if (refLocked) expD = dbgReq;
      else if (cpuReq && dbgReq) begin
        if (refLastDbg) expC = 1'b1;
        else expD = 1'b1;
      end else begin
        expC = cpuReq;
        expD = dbgReq;
      end
    end
  endtask

  // Compare every DUT output with the model (called mid-cycle).
  task automatic checkOutput();
    logic        eWe;
    logic [15:0] eAddr, eWdata;
    predictGrants();
    eWe = 1'b0;
    eAddr = 16'h0;
    eWdata = 16'h0;
    if (expC) begin
      eWe = cpuWe; eAddr = cpuAddr; eWdata = cpuWdata;
    end else if (expD) begin
      eWe = dbgWe; eAddr = dbgAddr; eWdata = dbgWdata;
    end
    checkBit("cpu_gnt", cpuGnt, expC);
    checkBit("dbg_gnt", dbgGnt, expD);
    checkBit("mem_we", memWe, eWe);
    checkWord("mem_addr", memAddr, eAddr);
    checkWord("mem_wdata", memWdata, eWdata);
    checkBit("locked", locked, refLocked);
    checkBit("cpu_rvalid", cpuRvalid, refCpuRvalid);
    checkBit("dbg_rvalid", dbgRvalid, refDbgRvalid);
    checkWord("cpu_rdata", cpuRdata, refCpuRdata);
    checkWord("dbg_rdata", dbgRdata, refDbgRdata);
  endtask

  // Advance the model across a rising edge.
  task automatic commitModel();
    if (rst) begin
      refLocked = 1'b0; refLastDbg = 1'b1; refHeld = 0;
      refCpuRvalid = 1'b0; refDbgRvalid = 1'b0;
      refCpuRdata = 16'h0; refDbgRdata = 16'h0;
    end else begin
      refCpuRvalid = expC && !cpuWe;
      refDbgRvalid = expD && !dbgWe;
      if (refCpuRvalid) refCpuRdata = refMem[cpuAddr];
      if (refDbgRvalid) refDbgRdata = refMem[dbgAddr];
      if (expC && cpuWe) refMem[cpuAddr] = cpuWdata;
      if (expD && dbgWe) refMem[dbgAddr] = dbgWdata;
      if (expC) refLastDbg = 1'b0;
      if (expD) refLastDbg = 1'b1;
      if (refLocked) begin
        if (!dbgLock || refHeld >= LOCK_MAX) begin
          refLocked = 1'b0;
          refLastDbg = 1'b1;
        end else begin
          refHeld++;
        end
      end else if (expD && dbgLock) begin
        refLocked = 1'b1;
        refHeld = 1;
      end
    end
  endtask

  task automatic midCycle();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic endCycle();
    @(posedge clk);
    commitModel();
    #1;
  endtask

  function automatic vec_t mkVec(input logic cReq, input logic [15:0] cAddr,
                                 input logic dReq, input logic dWe, input logic dLock,
                                 input logic [15:0] dAddr, input logic [15:0] dWdata,
                                 input logic eC, input logic eD, input logic eWe,
                                 input logic eL, input logic chk, input logic [15:0] eRd);
    vec_t v;
    v.cReq = cReq; v.cWe = 1'b0; v.cAddr = cAddr; v.cWdata = 16'h0;
    v.dReq = dReq; v.dWe = dWe; v.dLock = dLock; v.dAddr = dAddr; v.dWdata = dWdata;
    v.eCpuGnt = eC; v.eDbgGnt = eD; v.eMemWe = eWe; v.eLocked = eL;
    v.chkRd = chk; v.eRd = eRd;
    return v;
  endfunction

  // Main sequence: directed hand sequences, table vectors, then random.
  initial begin
    checkCount = 0;
    errorCount = 0;
    for (int i = 0; i < 65536; i++) begin
      memArray[i] = 16'(i) ^ 16'hA5A5;
      refMem[i]   = 16'(i) ^ 16'hA5A5;
    end
    memArray[16'h3000] = 16'h1234;
    refMem[16'h3000]   = 16'h1234;
    refLocked = 1'b0; refLastDbg = 1'b1; refHeld = 0;
    refCpuRvalid = 1'b0; refDbgRvalid = 1'b0;
    refCpuRdata = 16'h0; refDbgRdata = 16'h0;

    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk);
    #1;

    // Reset then idle.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      midCycle();
      endCycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    midCycle();
    checkBit("idle_locked", locked, 1'b0);
    checkWord("idle_cpu_rdata", cpuRdata, 16'h0);
    endCycle();

    // Tie after reset: CPU first, then DBG, read data one cycle later.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h3000, 16'h0, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h0);
    midCycle();
    checkBit("tie_cpu_gnt", cpuGnt, 1'b1);
    checkBit("tie_dbg_gnt", dbgGnt, 1'b0);
    endCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h0);
    midCycle();
    checkBit("tie_cpu_rvalid", cpuRvalid, 1'b1);
    checkWord("tie_cpu_rdata", cpuRdata, 16'h1234);
    checkBit("tie_dbg_gnt2", dbgGnt, 1'b1);
    endCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    midCycle();
    checkBit("tie_dbg_rvalid", dbgRvalid, 1'b1);
    checkWord("tie_dbg_rdata", dbgRdata, 16'hE5A5);
    endCycle();

    // Directed table: round-robin, write-then-read, lock with forced release.
    for (int i = 0; i < 6; i++)
      vecs.push_back(mkVec(1'b1, 16'h3001, 1'b1, 1'b0, 1'b0, 16'h4001, 16'h0,
                           (i % 2) == 0, (i % 2) == 1, 1'b0, 1'b0, 1'b0, 16'h0));
    vecs.push_back(mkVec(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h3005, 16'h0042,
                         1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0));
    vecs.push_back(mkVec(1'b1, 16'h3005, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0,
                         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
    vecs.push_back(mkVec(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0042));
    vecs.push_back(mkVec(1'b1, 16'h3002, 1'b1, 1'b0, 1'b1, 16'h4002, 16'h0,
                         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0));
    for (int i = 0; i < LOCK_MAX; i++)
      vecs.push_back(mkVec(1'b1, 16'h3002, 1'b1, 1'b0, 1'b1, 16'h4002, 16'h0,
                           1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0));
    vecs.push_back(mkVec(1'b1, 16'h3002, 1'b1, 1'b0, 1'b1, 16'h4002, 16'h0,
                         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
    vecs.push_back(mkVec(1'b1, 16'h3002, 1'b1, 1'b0, 1'b1, 16'h4002, 16'h0,
                         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0));
    foreach (vecs[i]) begin
      applyStimulus(1'b0, vecs[i].cReq, vecs[i].cWe, vecs[i].cAddr, vecs[i].cWdata,
                    vecs[i].dReq, vecs[i].dWe, vecs[i].dLock, vecs[i].dAddr, vecs[i].dWdata);
      midCycle();
      checkBit("vec_cpu_gnt", cpuGnt, vecs[i].eCpuGnt);
      checkBit("vec_dbg_gnt", dbgGnt, vecs[i].eDbgGnt);
      checkBit("vec_mem_we", memWe, vecs[i].eMemWe);
      checkBit("vec_locked", locked, vecs[i].eLocked);
      if (vecs[i].chkRd) checkWord("vec_cpu_rdata", cpuRdata, vecs[i].eRd);
      endCycle();
    end

    // Reset in the third locked cycle with a DBG write pending.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h3002, 16'h0, 1'b1, 1'b0, 1'b1, 16'h4002, 16'h0);
      midCycle();
      checkBit("lk_locked", locked, 1'b1);
      endCycle();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h3002, 16'h0, 1'b1, 1'b1, 1'b1, 16'h3006, 16'hBEEF);
    midCycle();
    checkBit("rstlk_dbg_gnt", dbgGnt, 1'b0);
    checkBit("rstlk_mem_we", memWe, 1'b0);
    endCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h3002, 16'h0, 1'b1, 1'b0, 1'b0, 16'h4002, 16'h0);
    midCycle();
    checkBit("rstlk_locked", locked, 1'b0);
    checkBit("rstlk_cpu_gnt", cpuGnt, 1'b1);
    endCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h3006, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    midCycle();
    endCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    midCycle();
    checkWord("rstlk_nowrite", cpuRdata, 16'h3006 ^ 16'hA5A5);
    endCycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic        r, cR, cW, dR, dW, dL;
      logic [15:0] cA, cD, dA, dD;
      r  = ($urandom_range(0, 63) == 0);
      cR = ($urandom_range(0, 3) != 0);
      cW = 1'($urandom_range(0, 1));
      dR = ($urandom_range(0, 3) != 0);
      dW = 1'($urandom_range(0, 1));
      dL = ($urandom_range(0, 7) != 0);
      cA = 16'h3000 + 16'($urandom_range(0, 7));
      dA = 16'h3000 + 16'($urandom_range(0, 7));
      cD = 16'($urandom);
      dD = 16'($urandom);
      applyStimulus(r, cR, cW, cA, cD, dR, dW, dL, dA, dD);
      midCycle();
      endCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/punc_mem_arbiter.md
Name: punc_mem_arbiter

Overview:
- Shares the single PUnC memory port between two requesters: the processor datapath/control (CPU) and the debug/loader port (DBG).
- Sits between the memory and both requesters. Memory is asynchronous-read, synchronous-write.
- Arbitration:
  - Round-robin between requesters.
  - DBG can lock the port for bounded bursts.
  - Read data is returned registered, one cycle after grant.

Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- LOCK_MAX, 8, max consecutive cycles DBG may hold a lock before forced release (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_rvalid  out  1  CPU read data valid (one cycle)
- cpu_rdata  out  DATA_W  CPU read data
- dbg_req  in  1  DBG access request, held until dbg_gnt
- dbg_we  in  1  DBG write / read
- dbg_lock  in  1  DBG requests exclusive ownership after its next grant
- dbg_addr  in  ADDR_W  DBG address
- dbg_wdata  in  DATA_W  DBG write data
- dbg_gnt  out  1  DBG access performed this cycle
- dbg_rvalid  out  1  DBG read data valid (one cycle)
- dbg_rdata  out  DATA_W  DBG read data
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory async read data
- locked  out  1  FSM in LOCK state

Behaviour:

Reset (rst=1 at posedge):
- state=NORMAL, last=DBG (so CPU wins the first tie), lock_cnt=0.
- cpu_rvalid=dbg_rvalid=0; cpu_rdata=dbg_rdata=0.
- While rst=1, cpu_gnt, dbg_gnt and mem_we are forced 0 combinationally.

Grant logic (combinational, same cycle as request; at most one grant per cycle):
- NORMAL, only one req: grant it.
- NORMAL, both req: grant the requester not equal to last.
- LOCK: only DBG may be granted. cpu_gnt=0 even if cpu_req=1.
- No grant: mem_addr=0, mem_we=0, mem_wdata=0.
- Granted requester drives mem_addr/mem_wdata; mem_we = its we.
- Write commits at the posedge ending the grant cycle.

last register:
- Updates to the granted requester on every grant.
- Unchanged on idle cycles.

Read return:
- On a granted read, mem_rdata is captured into that requester's rdata at the posedge.
- That requester's rvalid=1 for exactly the next cycle.
- rdata holds its value until the next read for that requester.
- Write grants produce no rvalid.
- Read-after-write to the same address in consecutive grants returns the new data.

FSM:
- NORMAL -> LOCK: when dbg_gnt=1 and dbg_lock=1. lock_cnt loads 1.
- LOCK, each cycle:
  - If dbg_lock=0, or lock_cnt==LOCK_MAX: go to NORMAL, set last=DBG.
  - Else: lock_cnt+1.
  - An access granted in the exit cycle still completes.
- LOCK_MAX forced release: the exit cycle itself may still grant DBG. In the following NORMAL cycle, CPU wins any tie because last=DBG. CPU is therefore never starved longer than LOCK_MAX+1 cycles.
- locked = (state==LOCK).

Boundaries:
- rst mid-access: write in the rst cycle is suppressed. Pending rvalid is cleared. Lock is released.
- Requester dropping req without gnt: legal, no side effects.
- Address/width: addresses pass through unmodified. No wrap logic (full ADDR_W space).

Test Plan:
- Reset then idle: rst 2 cycles, no req -> all gnt/rvalid=0, mem_we=0, locked=0, rdata=0.
- Tie after reset: cpu_req read 0x3000 (mem=0x1234) and dbg_req read 0x4000 same cycle -> cycle0 cpu_gnt. Cycle1 cpu_rvalid=1, cpu_rdata=0x1234, dbg_gnt=1. Cycle2 dbg_rvalid=1.
- Round-robin: both request continuously for 6 cycles -> grants alternate CPU,DBG,CPU,DBG,CPU,DBG.
- Write then read: DBG write 0x0042 to 0x3005, then CPU read 0x3005 -> cpu_rdata=0x0042, mem_we=1 only in the DBG grant cycle.
- Lock and forced release (LOCK_MAX=8): dbg_lock=1, dbg_req and cpu_req held high -> DBG granted for 9 consecutive cycles (1 entry + 8 locked), locked=1 throughout. Next cycle cpu_gnt=1, locked=0.
- Reset mid-lock: assert rst in 3rd locked cycle with DBG write pending -> no memory write that cycle. Next cycle state NORMAL, locked=0, CPU wins tie.
